// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and register bit positions for pwm_capture
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int LEVEL_BIT   = 29;
  localparam int OVF_BIT     = 30;
  localparam int VALID_BIT   = 31;

  localparam int EN_BIT      = 0;
  localparam int CLR_OVF_BIT = 1;
  localparam int IRQ_EN_BIT  = 2;

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - 2-flop synchronizer plus delay flop with rise/fall strobes
module pwm_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic s_q;
  logic s_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      s_q     <= meta_q;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;
  assign fall_o = ~s_q & s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - memory-mapped PWM period/high-time decoder
// Optional irq output and irq_en bit when PWM_CAPTURE_IRQ_EN is defined.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        wstrb,
  input  logic        rstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
  ,output logic       irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic valid_q, valid_d;
  logic ovf_q, ovf_d;
  logic en_q, en_d;

  logic s, rise, fall;
  logic wr, rd;
  logic wr_disable, wr_arm, wr_force;
  logic capture, sat;

  pwm_in_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(pwm_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign wr = sel & wstrb;
  assign rd = sel & rstrb;

  // A write that changes the enable overrides whatever the measurement would do this cycle.
  assign wr_disable = wr & ~wdata[EN_BIT];
  assign wr_arm     = wr & wdata[EN_BIT] & ~en_q;
  assign wr_force   = wr_disable | wr_arm;

  assign capture = (state_q == MEASURE) & rise & ~wr_force;
  assign sat     = (state_q == MEASURE) & ~rise & (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wr_disable) begin
      state_d = IDLE;
    end else if (wr_arm) begin
      state_d = ARM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARM:     if (rise) state_d = MEASURE;
        MEASURE: if (sat) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    high_lat_d = high_lat_q;
    if (wr_force) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        ARM:     cnt_d = rise ? CNT_ONE : '0;
        MEASURE: begin
          if (rise)     cnt_d = CNT_ONE;
          else if (sat) cnt_d = '0;
          else          cnt_d = cnt_q + CNT_ONE;
          if (fall) high_lat_d = cnt_q;
        end
        default: cnt_d = '0;
      endcase
    end
    if (capture) begin
      period_d = cnt_q;
      high_d   = high_lat_q;
    end
    valid_d = capture ? 1'b1 : (rd ? 1'b0 : valid_q);
    // Saturation set wins over a same-cycle software clear.
    ovf_d   = sat ? 1'b1 : ((wr & wdata[CLR_OVF_BIT]) ? 1'b0 : ovf_q);
    en_d    = wr ? wdata[EN_BIT] : en_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      period_q   <= '0;
      high_q     <= '0;
      high_lat_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      high_lat_q <= high_lat_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
    end
  end

  always_comb begin
    rdata                         = '0;
    rdata[CNT_W-1:0]              = period_q;
    rdata[2*CNT_W-1 -: CNT_W]     = high_q;
    rdata[LEVEL_BIT]              = s;
    rdata[OVF_BIT]                = ovf_q;
    rdata[VALID_BIT]              = valid_q;
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr) irq_en_q <= wdata[IRQ_EN_BIT];
      irq_q <= irq_en_q & (valid_q | ovf_q);
    end
  end

  assign irq = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:3];
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:2];
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture (reads checked by a monitor)
module tb_pwm_capture;

  localparam int CNT_W = 12;
  localparam logic [31:0] FULL  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOLVL = 32'hDFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        wstrb;
  logic        rstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        pwm_in;
`ifdef PWM_CAPTURE_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .wstrb (wstrb),
    .rstrb (rstrb),
    .wdata (wdata),
    .rdata (rdata),
    .pwm_in(pwm_in)
`ifdef PWM_CAPTURE_IRQ_EN
    ,.irq  (irq)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // pwm_in generator state: mode 0 = low, 1 = high, 2 = PWM with per/hi
  int mode  = 0;
  int per   = 1;
  int hi    = 0;
  int phase = 0;

  function automatic logic [31:0] word(int p, int h, bit lvl, bit ovf, bit vld);
    logic [31:0] r;
    r                     = '0;
    r[CNT_W-1:0]          = p[CNT_W-1:0];
    r[2*CNT_W-1 -: CNT_W] = h[CNT_W-1:0];
    r[29]                 = lvl;
    r[30]                 = ovf;
    r[31]                 = vld;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    sel   = 1'b0;
    wstrb = 1'b0;
    rstrb = 1'b0;
    wdata = '0;
    if (mode == 2) begin
      phase  = (phase + 1) % per;
      pwm_in = (phase < hi);
    end else begin
      pwm_in = (mode == 1);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    sel   = 1'b1;
    wstrb = 1'b1;
    wdata = d;
    cyc();
  endtask

  task automatic rd(input string nm, input logic [31:0] e, input logic [31:0] m);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    x.mask = m;
    sb_q.push_back(x);
    sel   = 1'b1;
    rstrb = 1'b1;
    cyc();
  endtask

  task automatic start_pwm(input int p, input int h);
    per   = p;
    hi    = h;
    phase = p - 1;
    mode  = 2;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < per && phase != p; i++) cyc();
    if (phase != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase=%0d required=%0d", phase, p);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sel && rstrb) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: rdata=%h with empty scoreboard", rdata);
      end else begin
        e = sb_q.pop_front();
        if ((rdata & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: rdata=%h required=%h mask=%h", e.name, rdata, e.exp, e.mask);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sel    = 1'b0;
    wstrb  = 1'b0;
    rstrb  = 1'b0;
    wdata  = '0;
    pwm_in = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    rd("reset_state", 32'h0, FULL);

    // period 16, high 5; in a cycle at phase p the synced level equals pin(p-2)
    wr(32'h1);
    start_pwm(16, 5);
    repeat (60) cyc();
    wait_phase(6);
    rd("cap16", word(16, 5, 1, 0, 1), FULL);
    rd("valid_cleared", word(16, 5, 0, 0, 0), FULL);

    // read coincident with a detected rise: capture beats the clear
    wait_phase(2);
    rd("read_at_rise", word(16, 5, 1, 0, 0), FULL);
    rd("after_rise", word(16, 5, 1, 0, 1), FULL);

    // 0% duty: saturate, level low
    mode = 0;
    repeat (4200) cyc();
    rd("ovf_low", word(16, 5, 0, 1, 0), FULL);
    wr(32'h3);
    rd("ovf_cleared", word(16, 5, 0, 0, 0), FULL);

    // 100% duty: saturate, level high, then 33% PWM resumes without re-enable
    mode = 1;
    repeat (4200) cyc();
    rd("ovf_high", word(16, 5, 1, 1, 0), FULL);
    start_pwm(15, 5);
    repeat (60) cyc();
    wait_phase(6);
    rd("cap15", word(15, 5, 1, 1, 1), FULL);

    // disable mid-measurement, re-enable: interrupted period is discarded
    wait_phase(8);
    wr(32'h0);
    wr(32'h1);
    wait_phase(3);
    rd("no_cap_after_reenable", word(15, 5, 1, 1, 0), FULL);
    wait_phase(3);
    rd("cap_after_reenable", word(15, 5, 1, 1, 1), FULL);

    // reset for one cycle mid-measurement
    wait_phase(8);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`ifdef PWM_CAPTURE_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_reset: irq=%b required=0", irq);
    end
`endif
    rd("reset_mid", 32'h0, FULL);
    repeat (40) cyc();
    rd("idle_after_reset", 32'h0, NOLVL);

    wr(32'h1);
    repeat (40) cyc();
    wait_phase(6);
    rd("recapture", word(15, 5, 1, 0, 1), FULL);

    repeat (3) cyc();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
